// File: rtl/multi_corr_v8.sv
// Multi-channel (A+B+C)^2 correlator with per-channel offset correction, peak
// tracking and a holdoff-gated threshold trigger. Five-stage pipeline.
module multi_corr_v8 #(
  parameter int NCORRS       = 4,
  parameter int DEMUX        = 16,
  parameter int NBITS        = 3,
  parameter int CORR_BITS    = 13,
  parameter int HOLDOFF_BITS = 8,
  parameter int IDX_BITS     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [NCORRS*DEMUX*NBITS-1:0] A,
  input  logic [NCORRS*DEMUX*NBITS-1:0] B,
  input  logic [NCORRS*DEMUX*NBITS-1:0] C,
  input  logic                        cfg_wr,
  input  logic [IDX_BITS-1:0]         cfg_addr,
  input  logic [CORR_BITS-1:0]        cfg_data,
  input  logic                        cfg_commit,
  input  logic [CORR_BITS-1:0]        thresh,
  input  logic [HOLDOFF_BITS-1:0]     holdoff,
  output logic [NCORRS*CORR_BITS-1:0] corr_out,
  output logic                        corr_valid,
  output logic [CORR_BITS-1:0]        peak_val,
  output logic [IDX_BITS-1:0]         peak_idx,
  output logic                        peak_valid,
  output logic                        trig
);

  localparam int W        = NCORRS*DEMUX*NBITS;
  localparam int NS       = NCORRS*DEMUX;
  localparam int SBITS    = NBITS + 2;
  localparam int SQ_BITS  = 2*SBITS;
  localparam int SUM_BITS = SQ_BITS + $clog2(DEMUX) + 1;
  localparam int DW       = ((SUM_BITS > CORR_BITS) ? SUM_BITS : CORR_BITS) + 1;
  localparam int HALF     = DEMUX/2;
  localparam logic [CORR_BITS-1:0] CMAX = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [W-1:0] a_r, b_r, c_r;
  logic         v1, v2, v3;

  logic [SQ_BITS-1:0]  sq_r [NS];
  logic [SUM_BITS-1:0] p0_n [NCORRS];
  logic [SUM_BITS-1:0] p1_n [NCORRS];
  logic [SUM_BITS-1:0] p0_r [NCORRS];
  logic [SUM_BITS-1:0] p1_r [NCORRS];

  logic [CORR_BITS-1:0] shadow_off [NCORRS];
  logic [CORR_BITS-1:0] active_off [NCORRS];
  logic [NCORRS*CORR_BITS-1:0] corr_n;

  logic [CORR_BITS-1:0] best_val;
  logic [IDX_BITS-1:0]  best_idx;
  logic [0:0]           state;
  logic [HOLDOFF_BITS-1:0] cnt;

  function automatic logic [SQ_BITS-1:0] sq_of(input logic [NBITS-1:0] a,
                                               input logic [NBITS-1:0] b,
                                               input logic [NBITS-1:0] c);
    logic signed [SBITS-1:0]   s;
    logic signed [SQ_BITS-1:0] p;
    s = SBITS'(signed'(a)) + SBITS'(signed'(b)) + SBITS'(signed'(c));
    p = SQ_BITS'(s) * SQ_BITS'(s);
    return p;
  endfunction

  // Full-precision subtract; sign bit of d flags a negative result.
  function automatic logic [CORR_BITS-1:0] correct(input logic [SUM_BITS-1:0] p0,
                                                   input logic [SUM_BITS-1:0] p1,
                                                   input logic [CORR_BITS-1:0] off);
    logic [DW-1:0] d;
    d = DW'(p0) + DW'(p1) - DW'(off);
    if (d[DW-1])
      return '0;
    else if (d > DW'(CMAX))
      return CMAX;
    else
      return d[CORR_BITS-1:0];
  endfunction

  // Stage 1: input capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_r <= A;
        b_r <= B;
        c_r <= C;
      end
    end
  end

  // Stage 2: per-sample square
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      for (int unsigned k = 0; k < NS; k++) sq_r[k] <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        for (int unsigned k = 0; k < NS; k++)
          sq_r[k] <= sq_of(a_r[k*NBITS +: NBITS], b_r[k*NBITS +: NBITS],
                           c_r[k*NBITS +: NBITS]);
      end
    end
  end

  // Stage 3: two half-sums per channel
  always_comb begin
    for (int unsigned i = 0; i < NCORRS; i++) begin
      p0_n[i] = '0;
      p1_n[i] = '0;
      for (int unsigned s = 0; s < DEMUX; s++) begin
        if (s < HALF)
          p0_n[i] = p0_n[i] + SUM_BITS'(sq_r[i*DEMUX + s]);
        else
          p1_n[i] = p1_n[i] + SUM_BITS'(sq_r[i*DEMUX + s]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0;
      for (int unsigned i = 0; i < NCORRS; i++) begin
        p0_r[i] <= '0;
        p1_r[i] <= '0;
      end
    end else begin
      v3 <= v2;
      if (v2) begin
        for (int unsigned i = 0; i < NCORRS; i++) begin
          p0_r[i] <= p0_n[i];
          p1_r[i] <= p1_n[i];
        end
      end
    end
  end

  // Offset registers; a same-cycle commit copies the pre-write shadow value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCORRS; i++) begin
        shadow_off[i] <= '0;
        active_off[i] <= '0;
      end
    end else begin
      if (cfg_commit) begin
        for (int unsigned i = 0; i < NCORRS; i++) active_off[i] <= shadow_off[i];
      end
      if (cfg_wr && (32'(cfg_addr) < 32'(NCORRS)))
        shadow_off[cfg_addr] <= cfg_data;
    end
  end

  // Stage 4: full sum, offset subtraction, clamp
  always_comb begin
    corr_n = '0;
    for (int unsigned i = 0; i < NCORRS; i++)
      corr_n[i*CORR_BITS +: CORR_BITS] = correct(p0_r[i], p1_r[i], active_off[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_out   <= '0;
      corr_valid <= 1'b0;
    end else begin
      corr_valid <= v3;
      if (v3) corr_out <= corr_n;
    end
  end

  // Stage 5: peak search, strict compare keeps the lowest index on ties
  always_comb begin
    best_val = corr_out[0 +: CORR_BITS];
    best_idx = '0;
    for (int unsigned i = 1; i < NCORRS; i++) begin
      if (corr_out[i*CORR_BITS +: CORR_BITS] > best_val) begin
        best_val = corr_out[i*CORR_BITS +: CORR_BITS];
        best_idx = IDX_BITS'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_val   <= '0;
      peak_idx   <= '0;
      peak_valid <= 1'b0;
      trig       <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
    end else begin
      peak_valid <= corr_valid;
      trig       <= 1'b0;
      if (corr_valid) begin
        peak_val <= best_val;
        peak_idx <= best_idx;
        case (state)
          ST_IDLE: begin
            if (best_val >= thresh) begin
              trig  <= 1'b1;
              cnt   <= holdoff;
              state <= (holdoff == '0) ? ST_IDLE : ST_HOLD;
            end
          end
          default: begin
            cnt <= cnt - 1'b1;
            if (cnt == HOLDOFF_BITS'(1)) state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_corr_v8.sv
// Directed bench for multi_corr_v8: a cycle-slotted behavioural model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_multi_corr_v8;
  localparam int NC = 4, DM = 16, NB = 3, CB = 13, HB = 8, IB = 2;
  localparam int W  = NC*DM*NB;
  localparam int LG = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0] A = '0, B = '0, C = '0;
  logic cfg_wr = 1'b0, cfg_commit = 1'b0;
  logic [IB-1:0] cfg_addr = '0;
  logic [CB-1:0] cfg_data = '0;
  logic [CB-1:0] thresh = '0;
  logic [HB-1:0] holdoff = '0;
  logic [NC*CB-1:0] corr_out;
  logic corr_valid, peak_valid, trig;
  logic [CB-1:0] peak_val;
  logic [IB-1:0] peak_idx;

  multi_corr_v8 #(.NCORRS(NC), .DEMUX(DM), .NBITS(NB), .CORR_BITS(CB),
                  .HOLDOFF_BITS(HB), .IDX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .C(C),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .thresh(thresh), .holdoff(holdoff),
    .corr_out(corr_out), .corr_valid(corr_valid), .peak_val(peak_val),
    .peak_idx(peak_idx), .peak_valid(peak_valid), .trig(trig));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outputs keyed by the cycle they must appear in
  logic             sl_cv   [64];
  logic [NC*CB-1:0] sl_corr [64];
  logic             sl_pv   [64];
  logic [CB-1:0]    sl_pval [64];
  logic [IB-1:0]    sl_pidx [64];
  logic             sl_trig [64];

  logic             lg_cv   [LG];
  logic [NC*CB-1:0] lg_corr [LG];
  logic [CB-1:0]    lg_pval [LG];
  logic [IB-1:0]    lg_pidx [LG];
  logic             lg_trig [LG];

  int sh_m [NC];
  int act_m[NC];
  int hold_left = 0;

  logic s_wr = 1'b0, s_commit = 1'b0, s_rst = 1'b1;
  logic [IB-1:0] s_addr = '0;
  logic [CB-1:0] s_data = '0;
  logic [W-1:0]  va = '0, vb = '0, vc = '0;

  task automatic clear_slots();
    for (int i = 0; i < 64; i++) begin
      sl_cv[i] = 1'b0; sl_corr[i] = '0; sl_pv[i] = 1'b0;
      sl_pval[i] = '0; sl_pidx[i] = '0; sl_trig[i] = 1'b0;
    end
  endtask

  // One clock: apply staged inputs and predict this input's results.
  task automatic tick(input logic v);
    int due, due5, e[NC], best, bidx, sa, sb, sc, s;
    logic signed [NB-1:0] t;
    logic [NC*CB-1:0] ev;
    @(posedge clk); #1;
    rst = s_rst; cfg_wr = s_wr; cfg_addr = s_addr; cfg_data = s_data;
    cfg_commit = s_commit; in_valid = v & ~s_rst; A = va; B = vb; C = vc;
    if (s_rst) begin
      clear_slots();
      for (int i = 0; i < NC; i++) begin sh_m[i] = 0; act_m[i] = 0; end
      hold_left = 0;
    end else begin
      if (s_commit) for (int i = 0; i < NC; i++) act_m[i] = sh_m[i];
      if (s_wr && int'(s_addr) < NC) sh_m[s_addr] = int'(s_data);
      due = (cyc + 4) % 64; due5 = (cyc + 5) % 64;
      sl_cv[due] = v; sl_pv[due5] = v; sl_trig[due5] = 1'b0;
      if (v) begin
        ev = '0;
        for (int i = 0; i < NC; i++) begin
          s = 0;
          for (int k = 0; k < DM; k++) begin
            t = va[(i*DM+k)*NB +: NB]; sa = t;
            t = vb[(i*DM+k)*NB +: NB]; sb = t;
            t = vc[(i*DM+k)*NB +: NB]; sc = t;
            s += (sa+sb+sc)*(sa+sb+sc);
          end
          e[i] = s - act_m[i];
          if (e[i] < 0) e[i] = 0;
          if (e[i] > (1<<CB)-1) e[i] = (1<<CB)-1;
          ev[i*CB +: CB] = CB'(e[i]);
        end
        best = e[0]; bidx = 0;
        for (int i = 1; i < NC; i++) if (e[i] > best) begin best = e[i]; bidx = i; end
        sl_corr[due] = ev; sl_pval[due5] = CB'(best); sl_pidx[due5] = IB'(bidx);
        if (hold_left > 0) hold_left--;
        else if (best >= int'(thresh)) begin sl_trig[due5] = 1'b1; hold_left = int'(holdoff); end
      end
    end
    s_wr = 1'b0; s_commit = 1'b0;
  endtask

  int kc;
  always @(negedge clk) begin
    kc = cyc % 64;
    if (cyc < LG) begin
      lg_cv[cyc] = corr_valid; lg_corr[cyc] = corr_out; lg_pval[cyc] = peak_val;
      lg_pidx[cyc] = peak_idx; lg_trig[cyc] = trig;
    end
    chk("corr_valid", 64'(corr_valid), 64'(sl_cv[kc]));
    if (sl_cv[kc]) chk("corr_out", 64'(corr_out), 64'(sl_corr[kc]));
    chk("peak_valid", 64'(peak_valid), 64'(sl_pv[kc]));
    chk("trig", 64'(trig), 64'(sl_trig[kc]));
    if (sl_pv[kc]) begin
      chk("peak_val", 64'(peak_val), 64'(sl_pval[kc]));
      chk("peak_idx", 64'(peak_idx), 64'(sl_pidx[kc]));
    end
  end

  task automatic clr_in(); va = '0; vb = '0; vc = '0; endtask
  task automatic setall(input int ch, input int val);
    logic [NB-1:0] t;
    t = NB'(val);
    for (int k = 0; k < DM; k++) begin
      va[(ch*DM+k)*NB +: NB] = t; vb[(ch*DM+k)*NB +: NB] = t; vc[(ch*DM+k)*NB +: NB] = t;
    end
  endtask
  task automatic drain(); repeat (8) tick(1'b0); endtask
  task automatic issue(output int c); tick(1'b1); c = cyc; endtask
  task automatic cfg(input int addr, input int data, input logic wr, input logic commit);
    s_addr = IB'(addr); s_data = CB'(data); s_wr = wr; s_commit = commit;
    tick(1'b0);
  endtask
  task automatic lit_corr(input string nm, input int c, input int ch, input int exp);
    logic [NC*CB-1:0] vv;
    vv = lg_corr[c+4];
    chk(nm, 64'(vv[ch*CB +: CB]), 64'(exp));
  endtask

  int c1, c2, c3, c4, c5, c6, c7, c8, c9, cr;
  int cs[6];
  initial begin
    for (int i = 0; i < NC; i++) begin sh_m[i] = 0; act_m[i] = 0; end
    clear_slots();
    s_rst = 1'b1; tick(1'b0); tick(1'b0);
    chk("reset corr_out", 64'(corr_out), 64'd0);
    chk("reset corr_valid", 64'(corr_valid), 64'd0);
    chk("reset peak_val", 64'(peak_val), 64'd0);
    chk("reset trig", 64'(trig), 64'd0);
    s_rst = 1'b0; tick(1'b0); tick(1'b0);

    // 1: all zero, thresh 0
    clr_in(); issue(c1); drain();
    chk("t1 latency T+3", 64'(lg_cv[c1+3]), 64'd0);
    chk("t1 latency T+4", 64'(lg_cv[c1+4]), 64'd1);
    chk("t1 corr", 64'(lg_corr[c1+4]), 64'd0);
    chk("t1 peak_idx", 64'(lg_pidx[c1+5]), 64'd0);
    chk("t1 trig", 64'(lg_trig[c1+5]), 64'd1);

    // 2: channel 2 ones, then channel 0 at -4, back to back
    clr_in(); setall(2, 1); issue(c2);
    clr_in(); setall(0, -4); issue(c3);
    clr_in(); drain();
    lit_corr("t2 corr2", c2, 2, 144);
    lit_corr("t2 corr0", c2, 0, 0);
    chk("t2 peak_idx", 64'(lg_pidx[c2+5]), 64'd2);
    chk("t2 peak_val", 64'(lg_pval[c2+5]), 64'd144);
    lit_corr("t2 corr0 neg", c3, 0, 2304);
    chk("t2 peak_val neg", 64'(lg_pval[c3+5]), 64'd2304);

    // 3: offsets
    cfg(1, 100, 1'b1, 1'b0); cfg(0, 0, 1'b0, 1'b1);
    setall(1, 1); issue(c4); drain();
    lit_corr("t3 off100", c4, 1, 44);
    cfg(1, 200, 1'b1, 1'b0); cfg(0, 0, 1'b0, 1'b1);
    issue(c5); drain();
    lit_corr("t3 clamp0", c5, 1, 0);
    cfg(1, 50, 1'b1, 1'b0);
    issue(c6); drain();
    lit_corr("t3 no commit", c6, 1, 0);
    cfg(1, 30, 1'b1, 1'b1);
    issue(c7); drain();
    lit_corr("t3 commit pre-write", c7, 1, 94);
    cfg(0, 0, 1'b0, 1'b1);
    issue(c8); drain();
    lit_corr("t3 commit later", c8, 1, 114);
    cfg(1, 0, 1'b1, 1'b1); cfg(0, 0, 1'b0, 1'b1);

    // 4: tie
    clr_in(); setall(1, 1); setall(3, 1); issue(c9); drain();
    chk("t4 tie idx", 64'(lg_pidx[c9+5]), 64'd1);
    chk("t4 tie val", 64'(lg_pval[c9+5]), 64'd144);

    // 5: holdoff
    thresh = CB'(100); holdoff = HB'(2);
    clr_in(); setall(1, 1);
    for (int i = 0; i < 5; i++) issue(cs[i]);
    clr_in(); issue(c1); drain();
    chk("t5 trig r1", 64'(lg_trig[cs[0]+5]), 64'd1);
    chk("t5 trig r2", 64'(lg_trig[cs[1]+5]), 64'd0);
    chk("t5 trig r3", 64'(lg_trig[cs[2]+5]), 64'd0);
    chk("t5 trig r4", 64'(lg_trig[cs[3]+5]), 64'd1);
    chk("t5 trig r5", 64'(lg_trig[cs[4]+5]), 64'd0);
    setall(1, 1);
    issue(cs[0]); issue(cs[1]); tick(1'b0); tick(1'b0);
    issue(cs[2]); issue(cs[3]); issue(cs[4]); drain();
    chk("t5 gap r1", 64'(lg_trig[cs[0]+5]), 64'd1);
    chk("t5 gap r2", 64'(lg_trig[cs[1]+5]), 64'd0);
    chk("t5 gap r3", 64'(lg_trig[cs[2]+5]), 64'd0);
    chk("t5 gap r4", 64'(lg_trig[cs[3]+5]), 64'd1);

    // 6: reset with results in flight
    thresh = '0; holdoff = '0;
    cfg(1, 100, 1'b1, 1'b0); cfg(0, 0, 1'b0, 1'b1);
    issue(c2); issue(c3); issue(c4);
    s_rst = 1'b1; tick(1'b0); tick(1'b0);
    s_rst = 1'b0; repeat (6) tick(1'b0);
    for (int k = c4; k <= c4 + 7; k++) chk("t6 no valid", 64'(lg_cv[k]), 64'd0);
    chk("t6 corr_out", 64'(corr_out), 64'd0);
    chk("t6 peak_val", 64'(peak_val), 64'd0);
    setall(1, 1); issue(cr); drain();
    chk("t6 post T+3", 64'(lg_cv[cr+3]), 64'd0);
    chk("t6 post T+4", 64'(lg_cv[cr+4]), 64'd1);
    lit_corr("t6 offset cleared", cr, 1, 144);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
